// File: rtl/cyclic_code_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cyclic_code_pkg                                               |
// | Purpose  : Shared constants, types and the syndrome step function for    |
// |            the systematic (15,11) cyclic code with generator x^4+x+1.    |
// |            The coder and the Meggitt decoder both use this package.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package cyclic_code_pkg;

   localparam int N     = 15;              // codeword length
   localparam int K     = 11;              // data length
   localparam int R     = N - K;           // syndrome width
   localparam int CNT_W = $clog2(N);       // bit-position counter width

   localparam logic [R:0]   GEN     = 5'b10011;  // MSB is x^R
   localparam logic [R-1:0] ERR_PAT = 4'b1001;   // x^(N-1) mod GEN

   typedef logic [R-1:0]     syn_t;
   typedef logic [CNT_W-1:0] cnt_t;

   // One division step: (syn * x + in_bit) mod GEN.
   // When the outgoing x^(R-1) term is set, the shift produces x^R, which
   // is reduced by XORing the low R bits of the generator.
   function automatic syn_t syn_step(input syn_t syn, input logic in_bit);
      syn_t nxt;
      nxt = {syn[R-2:0], in_bit};
      if (syn[R-1]) begin
         nxt = nxt ^ GEN[R-1:0];
      end
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cyclic_syndrome_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cyclic_syndrome_lfsr                                          |
// | Purpose  : R-bit register dividing a serial bit stream by GEN.           |
// |            Priority: load > clr > shift.                                 |
// | Ports    : clk, rst       clock, synchronous active-high reset           |
// |            clr            clear the remainder to zero                    |
// |            load/load_val  overwrite the remainder                        |
// |            shift/in_bit   advance one division step with in_bit         |
// |            pre_xor        pattern XORed into the remainder before a step |
// |            syn            current remainder                              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cyclic_syndrome_lfsr
   import cyclic_code_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load,
   input  syn_t load_val,
   input  logic shift,
   input  logic in_bit,
   input  syn_t pre_xor,
   output syn_t syn
);

   syn_t syn_q;
   syn_t syn_d;

   always_comb begin
      syn_d = syn_q;
      if (load) begin
         syn_d = load_val;
      end else if (clr) begin
         syn_d = '0;
      end else if (shift) begin
         syn_d = syn_step(syn_q ^ pre_xor, in_bit);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         syn_q <= '0;
      end else begin
         syn_q <= syn_d;
      end
   end

   assign syn = syn_q;

endmodule
`default_nettype wire

// File: rtl/cyclic_decoder_meggitt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cyclic_decoder_meggitt                                        |
// | Purpose  : Serial Meggitt decoder for the (15,11) cyclic code, GEN =     |
// |            x^4+x+1. A capture stage computes the syndrome while bits     |
// |            arrive; a free-running correction stage emits the buffered    |
// |            frame, flipping the single erroneous bit. The two stages are  |
// |            double-buffered so frames stream back-to-back.                |
// | Ports    : clk            clock                                          |
// |            rst            synchronous active-high reset                  |
// |            enable         qualifies `in`                                 |
// |            in             received bit, x^14 first                       |
// |            out            corrected bit, same order                      |
// |            out_valid      `out` carries one of the 11 data bits          |
// |            err_detected   1-cycle pulse: loaded frame syndrome nonzero   |
// |            err_corrected  `out` bit in this cycle was flipped            |
// | Config   : CYCLIC_DECODER_CORRECT_EN defined -> single-error correction; |
// |            undefined -> detection only (raw bits out, err_corrected=0).  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cyclic_decoder_meggitt
   import cyclic_code_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic in,
   output logic out,
   output logic out_valid,
   output logic err_detected,
   output logic err_corrected
);

   localparam cnt_t c_last_cnt = cnt_t'(N - 1);
   localparam cnt_t c_data_cnt = cnt_t'(K);

   // capture stage
   cnt_t           rx_cnt_q, rx_cnt_d;
   logic [N-2:0]   rx_buf_q, rx_buf_d;
   syn_t           rx_syn;
   syn_t           rx_syn_final;

   // correction stage
   logic [N-1:0]   cx_buf_q, cx_buf_d;
   cnt_t           cx_cnt_q, cx_cnt_d;
   logic           cx_act_q, cx_act_d;
   logic           err_det_q, err_det_d;

   logic           frame_end;
   logic           flip;

   assign frame_end    = enable & (rx_cnt_q == c_last_cnt);
   // Syndrome including the bit accepted on this edge; this is what gets
   // handed to the correction stage at frame end.
   assign rx_syn_final = syn_step(rx_syn, in);

   cyclic_syndrome_lfsr u_rx_syn (
      .clk      (clk),
      .rst      (rst),
      .clr      (frame_end),
      .load     (1'b0),
      .load_val ('0),
      .shift    (enable),
      .in_bit   (in),
      .pre_xor  ('0),
      .syn      (rx_syn)
   );

`ifdef CYCLIC_DECODER_CORRECT_EN
   syn_t cx_syn;

   // The correction syndrome is shifted with zero input. After j shifts a
   // single error at x^p reads x^(p+j) mod GEN, which equals ERR_PAT exactly
   // when the erroneous bit is at the buffer MSB. Removing ERR_PAT on the
   // flip returns the syndrome to zero for the rest of the frame.
   cyclic_syndrome_lfsr u_cx_syn (
      .clk      (clk),
      .rst      (rst),
      .clr      (1'b0),
      .load     (frame_end),
      .load_val (rx_syn_final),
      .shift    (cx_act_q),
      .in_bit   (1'b0),
      .pre_xor  (flip ? ERR_PAT : '0),
      .syn      (cx_syn)
   );

   assign flip = cx_act_q & (cx_syn == ERR_PAT);
`else
   assign flip = 1'b0;
`endif

   always_comb begin
      rx_cnt_d  = rx_cnt_q;
      rx_buf_d  = rx_buf_q;
      cx_buf_d  = cx_buf_q;
      cx_cnt_d  = cx_cnt_q;
      cx_act_d  = cx_act_q;
      err_det_d = 1'b0;

      if (enable) begin
         rx_buf_d = {rx_buf_q[N-3:0], in};
         rx_cnt_d = frame_end ? '0 : rx_cnt_q + cnt_t'(1);
      end

      // A load always wins over the end of the previous correction pass,
      // which is what gives gap-free streaming.
      if (frame_end) begin
         cx_buf_d  = {rx_buf_q, in};
         cx_cnt_d  = '0;
         cx_act_d  = 1'b1;
         err_det_d = |rx_syn_final;
      end else if (cx_act_q) begin
         cx_buf_d = {cx_buf_q[N-2:0], 1'b0};
         cx_cnt_d = cx_cnt_q + cnt_t'(1);
         cx_act_d = (cx_cnt_q != c_last_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_cnt_q  <= '0;
         rx_buf_q  <= '0;
         cx_buf_q  <= '0;
         cx_cnt_q  <= '0;
         cx_act_q  <= 1'b0;
         err_det_q <= 1'b0;
      end else begin
         rx_cnt_q  <= rx_cnt_d;
         rx_buf_q  <= rx_buf_d;
         cx_buf_q  <= cx_buf_d;
         cx_cnt_q  <= cx_cnt_d;
         cx_act_q  <= cx_act_d;
         err_det_q <= err_det_d;
      end
   end

   assign out           = cx_buf_q[N-1] ^ flip;
   assign out_valid     = cx_act_q & (cx_cnt_q < c_data_cnt);
   assign err_detected  = err_det_q;
   assign err_corrected = flip;

endmodule
`default_nettype wire
